// File: rtl/serv_ram_arbiter.sv
// Three-way arbiter sharing a single-port 32-bit RAM between a byte-wide host
// port, the SERV data bus and the SERV instruction bus (grant/access/response).
module serv_ram_arbiter #(
   parameter int AW              = 5,
   parameter int HOST_MAX_CONSEC = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW+1:0] host_addr,
   input  logic [7:0]    host_wdata,
   output logic [7:0]    host_rdata,
   output logic          host_ack,
   input  logic          ibus_cyc,
   input  logic [31:0]   ibus_adr,
   output logic [31:0]   ibus_rdt,
   output logic          ibus_ack,
   input  logic          dbus_cyc,
   input  logic [31:0]   dbus_adr,
   input  logic          dbus_we,
   input  logic [31:0]   dbus_dat,
   input  logic [3:0]    dbus_sel,
   output logic [31:0]   dbus_rdt,
   output logic          dbus_ack,
   output logic          ram_en,
   output logic [AW-1:0] ram_a,
   output logic [3:0]    ram_we,
   output logic [31:0]   ram_di,
   input  logic [31:0]   ram_do
);

   localparam logic [3:0] CNT_MAX  = 4'(HOST_MAX_CONSEC);
   localparam logic [1:0] SRC_HOST = 2'd0;
   localparam logic [1:0] SRC_DBUS = 2'd1;
   localparam logic [1:0] SRC_IBUS = 2'd2;

   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

   state_t          state_reg, state_next;
   logic [1:0]      src_reg, src_next;
   logic [AW-1:0]   addr_reg, addr_next;
   logic [3:0]      we_reg, we_next;
   logic [31:0]     di_reg, di_next;
   logic            oor_reg, oor_next;
   logic            rd_reg, rd_next;
   logic [1:0]      lane_reg, lane_next;
   logic [3:0]      cnt_reg, cnt_next;
   logic [7:0]      host_rdata_reg;
   logic [31:0]     ibus_rdt_reg, dbus_rdt_reg;

   logic            cpu_pending, host_skip, grant_host, grant_dbus;
   logic            dbus_oor, ibus_oor;
   logic [3:0]      host_we_lanes;
   logic [31:0]     host_di_lanes;
   logic [7:0]      host_byte;
   logic [31:0]     cpu_data;
   logic            in_access, in_resp;
   logic [3:0]      unused_adr_bits;

   assign unused_adr_bits = {dbus_adr[1:0], ibus_adr[1:0]};

   // The host may only be passed over once it has starved the CPU long enough.
   assign cpu_pending = dbus_cyc | ibus_cyc;
   assign host_skip   = (cnt_reg == CNT_MAX) && cpu_pending;
   assign grant_host  = host_req && !host_skip;
   assign grant_dbus  = !grant_host && dbus_cyc;

   assign dbus_oor = |dbus_adr[31:AW+2];
   assign ibus_oor = |ibus_adr[31:AW+2];

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign host_we_lanes[gi]        = host_we && (host_addr[1:0] == 2'(gi));
         assign host_di_lanes[8*gi +: 8] = (host_addr[1:0] == 2'(gi)) ? host_wdata : 8'h00;
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      src_next   = src_reg;
      addr_next  = addr_reg;
      we_next    = we_reg;
      di_next    = di_reg;
      oor_next   = oor_reg;
      rd_next    = rd_reg;
      lane_next  = lane_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (grant_host) begin
               state_next = ACCESS;
               src_next   = SRC_HOST;
               addr_next  = host_addr[AW+1:2];
               we_next    = host_we_lanes;
               di_next    = host_di_lanes;
               oor_next   = 1'b0;
               rd_next    = !host_we;
               lane_next  = host_addr[1:0];
               if (!cpu_pending)
                  cnt_next = 4'd0;
               else if (cnt_reg != CNT_MAX)
                  cnt_next = cnt_reg + 4'd1;
            end else if (grant_dbus) begin
               state_next = ACCESS;
               src_next   = SRC_DBUS;
               addr_next  = dbus_adr[AW+1:2];
               we_next    = dbus_we ? dbus_sel : 4'b0000;
               di_next    = dbus_dat;
               oor_next   = dbus_oor;
               rd_next    = !dbus_we;
               lane_next  = 2'd0;
               cnt_next   = 4'd0;
            end else if (ibus_cyc) begin
               state_next = ACCESS;
               src_next   = SRC_IBUS;
               addr_next  = ibus_adr[AW+1:2];
               we_next    = 4'b0000;
               di_next    = 32'h0;
               oor_next   = ibus_oor;
               rd_next    = 1'b1;
               lane_next  = 2'd0;
               cnt_next   = 4'd0;
            end
         end
         ACCESS:  state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         src_reg   <= SRC_HOST;
         addr_reg  <= '0;
         we_reg    <= 4'b0000;
         di_reg    <= 32'h0;
         oor_reg   <= 1'b0;
         rd_reg    <= 1'b0;
         lane_reg  <= 2'd0;
         cnt_reg   <= 4'd0;
      end else begin
         state_reg <= state_next;
         src_reg   <= src_next;
         addr_reg  <= addr_next;
         we_reg    <= we_next;
         di_reg    <= di_next;
         oor_reg   <= oor_next;
         rd_reg    <= rd_next;
         lane_reg  <= lane_next;
         cnt_reg   <= cnt_next;
      end
   end

   assign in_access = (state_reg == ACCESS);
   assign in_resp   = (state_reg == RESP);

   assign ram_en = in_access && !oor_reg;
   assign ram_we = ram_en ? we_reg : 4'b0000;
   assign ram_a  = addr_reg;
   assign ram_di = di_reg;

   assign host_ack = in_resp && (src_reg == SRC_HOST);
   assign dbus_ack = in_resp && (src_reg == SRC_DBUS);
   assign ibus_ack = in_resp && (src_reg == SRC_IBUS);

   always_comb begin
      case (lane_reg)
         2'd0:    host_byte = ram_do[7:0];
         2'd1:    host_byte = ram_do[15:8];
         2'd2:    host_byte = ram_do[23:16];
         default: host_byte = ram_do[31:24];
      endcase
   end
   assign cpu_data = oor_reg ? 32'h0 : ram_do;

   // RAM data only exists during the response cycle, so it is bypassed there and held afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         host_rdata_reg <= 8'h00;
         ibus_rdt_reg   <= 32'h0;
         dbus_rdt_reg   <= 32'h0;
      end else begin
         if (host_ack && rd_reg) host_rdata_reg <= host_byte;
         if (ibus_ack && rd_reg) ibus_rdt_reg   <= cpu_data;
         if (dbus_ack && rd_reg) dbus_rdt_reg   <= cpu_data;
      end
   end

   assign host_rdata = (host_ack && rd_reg) ? host_byte : host_rdata_reg;
   assign ibus_rdt   = (ibus_ack && rd_reg) ? cpu_data  : ibus_rdt_reg;
   assign dbus_rdt   = (dbus_ack && rd_reg) ? cpu_data  : dbus_rdt_reg;

endmodule

// File: tb/tb_serv_ram_arbiter.sv
// Directed bench for serv_ram_arbiter with a behavioural RAM32 model and
// hand-computed expectations.
module tb_serv_ram_arbiter;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          host_req = 1'b0, host_we = 1'b0;
   logic [AW+1:0] host_addr = '0;
   logic [7:0]    host_wdata = 8'h00;
   logic [7:0]    host_rdata;
   logic          host_ack;
   logic          ibus_cyc = 1'b0;
   logic [31:0]   ibus_adr = 32'h0;
   logic [31:0]   ibus_rdt;
   logic          ibus_ack;
   logic          dbus_cyc = 1'b0, dbus_we = 1'b0;
   logic [31:0]   dbus_adr = 32'h0, dbus_dat = 32'h0;
   logic [3:0]    dbus_sel = 4'h0;
   logic [31:0]   dbus_rdt;
   logic          dbus_ack;
   logic          ram_en;
   logic [AW-1:0] ram_a;
   logic [3:0]    ram_we;
   logic [31:0]   ram_di;
   logic [31:0]   ram_do;

   logic [31:0]   mem [0:31];
   logic          bd_en = 1'b0;
   logic [4:0]    bd_a = 5'd0;
   logic [31:0]   bd_d = 32'h0;

   int checks = 0;
   int errors = 0;
   logic [2:0] exp3;
   logic [1:0] exp2;

   always #5 clk = ~clk;

   serv_ram_arbiter #(.AW(AW), .HOST_MAX_CONSEC(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
      .host_wdata(host_wdata), .host_rdata(host_rdata), .host_ack(host_ack),
      .ibus_cyc(ibus_cyc), .ibus_adr(ibus_adr), .ibus_rdt(ibus_rdt), .ibus_ack(ibus_ack),
      .dbus_cyc(dbus_cyc), .dbus_adr(dbus_adr), .dbus_we(dbus_we), .dbus_dat(dbus_dat),
      .dbus_sel(dbus_sel), .dbus_rdt(dbus_rdt), .dbus_ack(dbus_ack),
      .ram_en(ram_en), .ram_a(ram_a), .ram_we(ram_we), .ram_di(ram_di), .ram_do(ram_do)
   );

   // RAM32 model: read-before-write, data one cycle after EN; bd_* is a preload backdoor.
   always @(posedge clk) begin
      if (bd_en) begin
         mem[bd_a] <= bd_d;
      end else if (ram_en) begin
         for (int i = 0; i < 4; i++)
            if (ram_we[i]) mem[ram_a][8*i +: 8] <= ram_di[8*i +: 8];
         ram_do <= mem[ram_a];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      bd_en = 1'b1; bd_a = a; bd_d = d;
      @(negedge clk);
      bd_en = 1'b0;
   endtask

   task automatic host_txn(input logic we, input logic [6:0] addr, input logic [7:0] wd,
                           input logic [3:0] exp_we, input logic [31:0] exp_di,
                           input logic [7:0] exp_rd);
      @(negedge clk);
      host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wd;
      chk("host_idle_ack", host_ack, 0);
      @(negedge clk);
      chk("host_ram_en", ram_en, 1);
      chk("host_ram_a", ram_a, addr[6:2]);
      chk("host_ram_we", ram_we, exp_we);
      if (we) chk("host_ram_di", ram_di, exp_di);
      chk("host_early_ack", host_ack, 0);
      @(negedge clk);
      chk("host_ack", host_ack, 1);
      if (!we) chk("host_rdata", host_rdata, exp_rd);
      host_req = 1'b0;
      @(negedge clk);
      chk("host_ack_end", host_ack, 0);
      if (!we) chk("host_rdata_hold", host_rdata, exp_rd);
      $display("host %s addr=%h wdata=%h rdata=%h", we ? "wr" : "rd", addr, wd, host_rdata);
   endtask

   task automatic cpu_txn(input logic is_ibus, input logic we, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel, input logic exp_en,
                          input logic [3:0] exp_we, input logic [31:0] exp_rdt);
      @(negedge clk);
      if (is_ibus) begin
         ibus_cyc = 1'b1; ibus_adr = adr;
      end else begin
         dbus_cyc = 1'b1; dbus_we = we; dbus_adr = adr; dbus_dat = dat; dbus_sel = sel;
      end
      @(negedge clk);
      chk("cpu_ram_en", ram_en, exp_en);
      chk("cpu_ram_we", ram_we, exp_we);
      if (exp_en) chk("cpu_ram_a", ram_a, adr[6:2]);
      if (exp_en && we) chk("cpu_ram_di", ram_di, dat);
      chk("cpu_early_ack", {dbus_ack, ibus_ack}, 0);
      @(negedge clk);
      chk("cpu_ack", {dbus_ack, ibus_ack}, is_ibus ? 2'b01 : 2'b10);
      if (!we) chk("cpu_rdt", is_ibus ? ibus_rdt : dbus_rdt, exp_rdt);
      ibus_cyc = 1'b0; dbus_cyc = 1'b0;
      @(negedge clk);
      chk("cpu_ack_end", {dbus_ack, ibus_ack}, 0);
      if (!we) chk("cpu_rdt_hold", is_ibus ? ibus_rdt : dbus_rdt, exp_rdt);
      $display("%s %s adr=%h dat=%h sel=%b rdt=%h", is_ibus ? "ibus" : "dbus",
               we ? "wr" : "rd", adr, dat, sel, is_ibus ? ibus_rdt : dbus_rdt);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #2;
      chk("rst_host_ack", host_ack, 0);
      chk("rst_ibus_ack", ibus_ack, 0);
      chk("rst_dbus_ack", dbus_ack, 0);
      chk("rst_ram_en", ram_en, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_ram_a", ram_a, 0);
      chk("rst_ram_di", ram_di, 0);
      chk("rst_host_rdata", host_rdata, 0);
      chk("rst_ibus_rdt", ibus_rdt, 0);
      chk("rst_dbus_rdt", dbus_rdt, 0);
      for (int i = 0; i < 32; i++) preload(i[4:0], 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Host byte write then read back
      host_txn(1'b1, 7'h06, 8'hA5, 4'b0100, 32'h00A5_0000, 8'h00);
      chk("mem1_after_host_wr", mem[1], 32'h00A5_0000);
      host_txn(1'b0, 7'h06, 8'h00, 4'b0000, 32'h0, 8'hA5);

      // dbus partial write over preloaded word, ibus fetch of the merged word
      preload(5'd2, 32'h1122_3344);
      cpu_txn(1'b0, 1'b1, 32'h8, 32'hDEAD_BEEF, 4'b0011, 1'b1, 4'b0011, 32'h0);
      cpu_txn(1'b1, 1'b0, 32'h8, 32'h0, 4'b0000, 1'b1, 4'b0000, 32'h1122_BEEF);

      // Simultaneous requests: host, dbus, ibus at cycles 2, 5, 8
      @(negedge clk);
      host_req = 1'b1; host_we = 1'b0; host_addr = 7'h06;
      dbus_cyc = 1'b1; dbus_we = 1'b0; dbus_adr = 32'h8;
      ibus_cyc = 1'b1; ibus_adr = 32'h0;
      for (int c = 0; c < 10; c++) begin
         exp3 = (c == 2) ? 3'b100 : (c == 5) ? 3'b010 : (c == 8) ? 3'b001 : 3'b000;
         chk($sformatf("prio_acks_c%0d", c), {host_ack, dbus_ack, ibus_ack}, exp3);
         if (host_ack) begin chk("prio_host_rdata", host_rdata, 8'hA5); host_req = 1'b0; end
         if (dbus_ack) begin chk("prio_dbus_rdt", dbus_rdt, 32'h1122_BEEF); dbus_cyc = 1'b0; end
         if (ibus_ack) begin chk("prio_ibus_rdt", ibus_rdt, 32'h0); ibus_cyc = 1'b0; end
         @(negedge clk);
      end
      $display("prio sequence host/dbus/ibus done");

      // Starvation bound: four host grants, then ibus, then host again
      host_req = 1'b1; host_we = 1'b0; host_addr = 7'h06;
      ibus_cyc = 1'b1; ibus_adr = 32'h0;
      for (int c = 0; c < 18; c++) begin
         exp2[1] = (c == 2) || (c == 5) || (c == 8) || (c == 11) || (c == 17);
         exp2[0] = (c == 14);
         chk($sformatf("starve_acks_c%0d", c), {host_ack, ibus_ack}, exp2);
         if (ibus_ack) ibus_cyc = 1'b0;
         if (c == 17) host_req = 1'b0;
         @(negedge clk);
      end
      $display("starvation sequence done");

      // Out-of-range dbus read and write leave RAM untouched
      preload(5'd0, 32'hCAFE_F00D);
      preload(5'd3, 32'h7777_7777);
      cpu_txn(1'b0, 1'b0, 32'h0000_0200, 32'h0, 4'b0000, 1'b0, 4'b0000, 32'h0);
      cpu_txn(1'b0, 1'b1, 32'h0000_0200, 32'hFFFF_FFFF, 4'b1111, 1'b0, 4'b0000, 32'h0);
      cpu_txn(1'b1, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b1, 4'b0000, 32'hCAFE_F00D);

      // Reset during the ACCESS cycle of a host write
      @(negedge clk);
      host_req = 1'b1; host_we = 1'b1; host_addr = 7'h0C; host_wdata = 8'h5A;
      @(negedge clk);
      chk("abort_ram_en_before", ram_en, 1);
      chk("abort_ram_we_before", ram_we, 4'b0001);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_ram_en", ram_en, 0);
      chk("abort_ram_we", ram_we, 0);
      chk("abort_ram_a", ram_a, 0);
      chk("abort_ram_di", ram_di, 0);
      chk("abort_host_rdata", host_rdata, 0);
      chk("abort_ibus_rdt", ibus_rdt, 0);
      chk("abort_dbus_rdt", dbus_rdt, 0);
      host_req = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("abort_no_ack", {host_ack, dbus_ack, ibus_ack}, 0);
      end
      rst_n = 1'b1;
      chk("abort_mem3_unchanged", mem[3], 32'h7777_7777);
      $display("reset abort of host write done");
      host_txn(1'b0, 7'h0C, 8'h00, 4'b0000, 32'h0, 8'h77);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/serv_ram_arbiter.md
Name: serv_ram_arbiter

Overview:
- Shares the single-port RAM32 macro (32 words × 32 bits, byte write enables, one-cycle synchronous read) between three requesters.
- Requesters, in priority order: an external byte-wide host port (from the TT pins), the SERV data bus, and the SERV instruction bus.
- Each access runs as a fixed three-phase sequence: grant, RAM access, response.
- A bounded-starvation counter keeps the CPU making progress while the host streams requests.

Parameters:
- AW, 5: RAM word-address width (2^AW words).
- HOST_MAX_CONSEC, 4: maximum consecutive host grants while a CPU request is pending (range 1–15).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- host_req  in  1  host access request; level, held until host_ack
- host_we  in  1  host write (1) / read (0)
- host_addr  in  AW+2  host byte address
- host_wdata  in  8  host write byte
- host_rdata  out  8  host read byte; holds its value between reads
- host_ack  out  1  one-cycle completion pulse
- ibus_cyc  in  1  SERV instruction fetch request
- ibus_adr  in  32  fetch byte address
- ibus_rdt  out  32  fetch data; valid when ibus_ack=1
- ibus_ack  out  1  one-cycle completion pulse
- dbus_cyc  in  1  SERV data request
- dbus_adr  in  32  data byte address
- dbus_we  in  1  data write
- dbus_dat  in  32  data write word
- dbus_sel  in  4  data byte enables
- dbus_rdt  out  32  data read word; valid when dbus_ack=1
- dbus_ack  out  1  one-cycle completion pulse
- ram_en  out  1  RAM EN0
- ram_a  out  AW  RAM A0 (word address)
- ram_we  out  4  RAM WE0 byte enables
- ram_di  out  32  RAM Di0
- ram_do  in  32  RAM Do0 (valid the cycle after ram_en)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All acks=0, ram_en=0, ram_we=0, ram_a=0, ram_di=0.
  - host_rdata=0, ibus_rdt=0, dbus_rdt=0.
  - Starvation counter=0.
  - Reset mid-transaction abandons it: no ack is issued, and no RAM write occurs after rst_n falls.
- States: IDLE -> ACCESS -> RESP -> IDLE.
- Latency: request sampled in IDLE at cycle N; ack at cycle N+2; next grant no earlier than cycle N+3.
- IDLE:
  - Arbitrate among asserted requests.
  - Latch winner id, word address, write enables, write data and range flag.
  - Go to ACCESS. Stay in IDLE if there are no requests.
- Priority: host > dbus > ibus.
  - Exception: if the counter equals HOST_MAX_CONSEC and dbus_cyc|ibus_cyc is asserted, the host is skipped for that grant.
- Starvation counter:
  - Increments on each host grant made while a CPU request is pending.
  - Clears on any CPU grant, or on a host grant with no CPU request pending.
  - Saturates at HOST_MAX_CONSEC.
- ACCESS:
  - ram_en=1; ram_a = latched word address (addr[AW+1:2]); ram_we/ram_di from latches.
  - Outside ACCESS, ram_en=0 and ram_we=0.
- Write encoding:
  - dbus: ram_we = dbus_sel when dbus_we=1, else 0; ram_di = dbus_dat.
  - host: ram_we is one-hot at lane host_addr[1:0] when host_we=1; ram_di = host_wdata << (8×lane), other lanes 0.
  - ibus: never writes.
- RESP:
  - Pulse the winner's ack for exactly one cycle.
  - Winner's rdt = ram_do, or the host byte ram_do[8×lane +: 8] using the lane latched at grant.
  - Non-winners' ack=0.
  - Read-data outputs are registered and hold until the next read response to the same port.
- Out-of-range access:
  - Condition: CPU address bits [31:AW+2] nonzero.
  - Ram_en stays 0 in ACCESS (no write).
  - Ack is still issued at N+2, with rdt=0.
  - Host addresses are always in range.
- Requester drops its request after grant: the transaction completes (any write is performed) and the ack still pulses; the requester ignores it.
- Simultaneous requests: exactly one grant per IDLE cycle; losers remain pending and are not acked.
- Requests are level-sensitive: a request still asserted in the IDLE cycle after its ack is treated as a new access. Requesters must deassert in the cycle following ack, as SERV does.

Test Plan:
- Reset, host write 0xA5 to byte addr 0x06, then host read 0x06 -> WE=0b0100 at a=1 with di=0x00A50000; host_ack at N+2; host_rdata=0xA5.
- dbus write 0xDEADBEEF, sel=0b0011, adr=0x8, over a preloaded 0x11223344; then ibus read adr=0x8 -> ram_we=0011; ibus_rdt=0x1122BEEF; ibus_ack exactly one cycle.
- host_req, dbus_cyc and ibus_cyc asserted together -> grant order host, dbus, ibus; acks at cycles 2, 5, 8; never two acks in the same cycle.
- host_req held high continuously with ibus_cyc asserted, HOST_MAX_CONSEC=4 -> four host acks, then ibus_ack, then host resumes.
- dbus read from adr=0x00000200 (out of range) -> ram_en stays 0; dbus_ack at N+2 with dbus_rdt=0; a subsequent RAM read shows the contents unchanged.
- rst_n pulled low during the ACCESS cycle of a host write -> no host_ack; all outputs return to reset values asynchronously; after release the first request is serviced with normal 2-cycle latency.
